fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of Instruction_Memory.
- Owns the program counter and drives the word address into the combinational-read instruction memory.
- Registers the returned word and its PC into an IF/ID output register, which feeds decode through a valid/ready handshake.
- Supports start, branch/jump redirect, downstream backpressure and halt-on-sentinel.

---
 rtl/fetch_stage.sv | 108 ++++++++++
 tb/tb_fetch_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the program counter, addresses a
// combinational-read instruction memory and registers the returned word
// plus its PC into an IF/ID register handed to decode via valid/ready.
// Supports start, branch/jump redirect, downstream backpressure and a
// halt-on-sentinel word.
module fetch_stage #(
  parameter int                     ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
  parameter logic [31:0]            HALT_WORD  = 32'hFFFF_FFFF,
  parameter int                     CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [31:0]           imem_addr,
  input  logic [31:0]           imem_rdata,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   pc;
  logic                    slot_free;
  logic                    redirect_take;
  logic                    fetch_fire;
  logic                    halt_hit;

  // The PC is presented to the memory at all times, zero-extended.
  assign imem_addr = {{(32-ADDR_WIDTH){1'b0}}, pc};
  assign halted    = (state == S_HALT);

  // Handshake / control decode shared by every register below.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    slot_free     = !out_valid || out_ready;
    redirect_take = redirect_valid && (state != S_IDLE);
    fetch_fire    = (state == S_RUN) && slot_free && !redirect_valid;
    halt_hit      = fetch_fire && (imem_rdata == HALT_WORD);
  end

  // Next-state logic: a redirect always returns to RUN and beats halt detection.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (start) state_next = S_RUN;
      S_RUN: begin
        if (redirect_take) state_next = S_RUN;
        else if (halt_hit) state_next = S_HALT;
      end
      S_HALT: if (redirect_take) state_next = S_RUN;
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state always uses non-blocking assignment to avoid ordering races.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Program counter: redirect target, else advance on a non-halting fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       pc <= RESET_PC;
    else if (redirect_take)           pc <= redirect_pc;
    else if (fetch_fire && !halt_hit) pc <= pc + PC_ONE;
  end

  // IF/ID register: squash on redirect, load on fetch, drain on a bare accept.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the payload is reset too because its reset value is architecturally visible.
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
    end else if (redirect_take) begin
      out_valid <= 1'b0;
    end else if (fetch_fire) begin
      out_valid <= 1'b1;
      out_instr <= imem_rdata;
      out_pc    <= pc;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating count of fetches performed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             fetch_count <= '0;
    else if (fetch_fire && fetch_count != '1) fetch_count <= fetch_count + CNT_ONE;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: two instances (8-bit PC / 16-bit counter, and
// 2-bit PC / 4-bit counter) share control inputs, each with its own memory
// and a cycle-level behavioural model. A single negedge process compares
// every output against the models; directed phases pin literal values.
module tb_fetch_stage;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

  typedef struct {
    int          st;
    int          pc;
    bit          vld;
    logic [31:0] instr;
    int          opc;
    int          cnt;
  } mdl_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic [1:0]  redirect_pc_b;

  logic [31:0] imem_addr_a, imem_rdata_a, out_instr_a;
  logic        out_valid_a, halted_a;
  logic [7:0]  out_pc_a;
  logic [15:0] fetch_count_a;

  logic [31:0] imem_addr_b, imem_rdata_b, out_instr_b;
  logic        out_valid_b, halted_b;
  logic [1:0]  out_pc_b;
  logic [3:0]  fetch_count_b;

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [4];

  int n_cmp = 0;
  int n_fail = 0;

  mdl_t ma, mb;

  always #5 clk = ~clk;

  assign redirect_pc_b = redirect_pc[1:0];
  assign imem_rdata_a  = mem_a[imem_addr_a[7:0]];
  assign imem_rdata_b  = mem_b[imem_addr_b[1:0]];

  fetch_stage #(.ADDR_WIDTH(8), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_addr(imem_addr_a), .imem_rdata(imem_rdata_a),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_instr(out_instr_a), .out_pc(out_pc_a),
    .halted(halted_a), .fetch_count(fetch_count_a)
  );

  fetch_stage #(.ADDR_WIDTH(2), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_addr(imem_addr_b), .imem_rdata(imem_rdata_b),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc_b),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_instr(out_instr_b), .out_pc(out_pc_b),
    .halted(halted_b), .fetch_count(fetch_count_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.st = M_IDLE; m.pc = 0; m.vld = 1'b0; m.instr = '0; m.opc = 0; m.cnt = 0;
    return m;
  endfunction

  // One clock of the fetch rules, written directly from the behavioural description.
  function automatic mdl_t mdl_step(mdl_t m, bit st_in, bit rdy, bit rv, int rpc,
                                    logic [31:0] word, int aw, int cw);
    mdl_t n = m;
    bit free = !m.vld || rdy;
    if (m.st == M_IDLE) begin
      if (m.vld && rdy) n.vld = 1'b0;
      if (st_in) n.st = M_RUN;
    end else if (rv) begin
      n.pc = rpc % (1 << aw);
      n.vld = 1'b0;
      n.st = M_RUN;
    end else begin
      if (m.vld && rdy) n.vld = 1'b0;
      if (m.st == M_RUN && free) begin
        n.vld = 1'b1;
        n.instr = word;
        n.opc = m.pc;
        n.cnt = (m.cnt == (1 << cw) - 1) ? m.cnt : m.cnt + 1;
        if (word == HALT) n.st = M_HALT;
        else n.pc = (m.pc + 1) % (1 << aw);
      end
    end
    return n;
  endfunction

  // Reference models advance on the same edges as the DUTs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= mdl_reset();
      mb <= mdl_reset();
    end else begin
      ma <= mdl_step(ma, start, out_ready, redirect_valid, int'(redirect_pc), mem_a[ma.pc], 8, 16);
      mb <= mdl_step(mb, start, out_ready, redirect_valid, int'(redirect_pc), mem_b[mb.pc], 2, 4);
    end
  end

  // Compare process: every output of both instances, every cycle, away from the active edge.
  always @(negedge clk) begin
    check("a_valid",  out_valid_a,   ma.vld);
    check("a_addr",   imem_addr_a,   ma.pc);
    check("a_halted", halted_a,      ma.st == M_HALT);
    check("a_count",  fetch_count_a, ma.cnt);
    if (ma.vld) begin
      check("a_instr", out_instr_a, ma.instr);
      check("a_pc",    out_pc_a,    ma.opc);
    end
    check("b_valid",  out_valid_b,   mb.vld);
    check("b_addr",   imem_addr_b,   mb.pc);
    check("b_halted", halted_b,      mb.st == M_HALT);
    check("b_count",  fetch_count_b, mb.cnt);
    if (mb.vld) begin
      check("b_instr", out_instr_b, mb.instr);
      check("b_pc",    out_pc_b,    mb.opc);
    end
  end

  task automatic drive(input bit s, input bit r, input bit rv, input logic [7:0] rpc);
    start = s; out_ready = r; redirect_valid = rv; redirect_pc = rpc;
  endtask

  // Advance one clock; returns just after the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_word(input bit allow_halt);
    logic [31:0] w;
    if (allow_halt && ($urandom % 12 == 0)) return HALT;
    w = $urandom;
    if (w == HALT) w = 32'h0;
    return w;
  endfunction

  task automatic expect_out(input string tag, input logic [31:0] instr, input logic [7:0] pc,
                            input logic [31:0] addr);
    check({tag, "_valid"}, out_valid_a, 1'b1);
    check({tag, "_instr"}, out_instr_a, instr);
    check({tag, "_pc"},    out_pc_a,    pc);
    check({tag, "_addr"},  imem_addr_a, addr);
  endtask

  initial begin
    logic [1:0] exp_b_pc [6];
    for (int i = 0; i < 256; i++) mem_a[i] = rnd_word(1'b0);
    for (int i = 0; i < 4; i++)   mem_b[i] = rnd_word(1'b0);
    mem_a[0] = 32'h4800_0005;
    mem_a[1] = 32'h4900_0004;
    mem_a[2] = 32'h4880_0000;
    mem_a[3] = HALT;

    // Reset values.
    drive(0, 0, 0, 8'd0);
    step(); step();
    rst_n = 1'b1;
    check("rst_valid", out_valid_a, 1'b0);
    check("rst_instr", out_instr_a, 32'h0);
    check("rst_pc",    out_pc_a,    8'h0);
    check("rst_count", fetch_count_a, 16'h0);
    check("rst_halted", halted_a, 1'b0);
    check("rst_addr",  imem_addr_a, 32'h0);

    // Start: no fetch in the start cycle itself.
    drive(1, 1, 0, 8'd0);
    step();
    check("start_valid", out_valid_a, 1'b0);
    check("start_addr",  imem_addr_a, 32'h0);
    drive(0, 1, 0, 8'd0);
    step(); expect_out("seq0", 32'h4800_0005, 8'd0, 32'd1);
    step(); expect_out("seq1", 32'h4900_0004, 8'd1, 32'd2);

    // Backpressure holds everything for three cycles.
    drive(0, 0, 0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      step(); expect_out("stall", 32'h4900_0004, 8'd1, 32'd2);
    end
    drive(0, 1, 0, 8'd0);
    step(); expect_out("seq2", 32'h4880_0000, 8'd2, 32'd3);
    check("seq_count", fetch_count_a, 16'd3);

    // Redirect squashes a stalled entry.
    drive(0, 0, 1, 8'd0);
    step();
    check("squash_valid", out_valid_a, 1'b0);
    check("squash_addr",  imem_addr_a, 32'd0);
    check("squash_count", fetch_count_a, 16'd3);
    drive(0, 1, 0, 8'd0);
    step(); expect_out("redir0", 32'h4800_0005, 8'd0, 32'd1);
    step(); step();
    step(); expect_out("halt", HALT, 8'd3, 32'd3);
    check("halt_flag",  halted_a, 1'b1);
    check("halt_count", fetch_count_a, 16'd7);
    for (int i = 0; i < 2; i++) begin
      step();
      check("halt_idle_valid", out_valid_a, 1'b0);
      check("halt_idle_addr",  imem_addr_a, 32'd3);
    end

    // Redirect out of HALT.
    drive(0, 1, 1, 8'd1);
    step();
    check("unhalt_flag",  halted_a, 1'b0);
    check("unhalt_valid", out_valid_a, 1'b0);
    drive(0, 1, 0, 8'd0);
    step(); expect_out("unhalt", 32'h4900_0004, 8'd1, 32'd2);
    check("unhalt_count", fetch_count_a, 16'd8);

    // Asynchronous reset between edges, then no fetch until start.
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid_a, 1'b0);
    check("arst_count", fetch_count_a, 16'h0);
    check("arst_addr",  imem_addr_a, 32'h0);
    check("arst_b_valid", out_valid_b, 1'b0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_valid", out_valid_a, 1'b0);
      check("idle_count", fetch_count_a, 16'h0);
    end

    // Two-bit PC wraps 0,1,2,3,0,1.
    exp_b_pc = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    drive(1, 1, 0, 8'd0);
    step();
    drive(0, 1, 0, 8'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("wrap_b_valid", out_valid_b, 1'b1);
      check("wrap_b_pc",    out_pc_b,    exp_b_pc[i]);
    end

    // Randomized run against the models.
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) mem_a[i] = rnd_word(1'b1);
    for (int i = 0; i < 4; i++)   mem_b[i] = rnd_word(1'b1);
    step();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      drive(($urandom % 8) == 0, ($urandom % 4) != 0, ($urandom % 12) == 0, 8'($urandom));
      if ($urandom % 700 == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
